// File: rtl/acc_alu_pkg.sv
// Shared types and constants for the acc_alu accumulator/ALU stage.
// Opcode 111 decodes as MUL when ACC_ALU_MUL_EN is defined, otherwise as SHR.
package acc_alu_pkg;

  localparam int W     = 4;
  localparam int CNT_W = $clog2(W);

  typedef enum logic [2:0] {
    OP_LDA = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
`ifdef ACC_ALU_MUL_EN
    OP_MUL = 3'b111
`else
    OP_SHR = 3'b111
`endif
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [W-1:0] RST_ACC = '0;
  localparam logic         RST_C   = 1'b0;

endpackage

// File: rtl/acc_alu_if.sv
// Control-unit handshake and operand/result bus of the acc_alu stage.
interface acc_alu_if;
  import acc_alu_pkg::*;

  logic         start_i;
  logic [2:0]   op_i;
  logic [W-1:0] ACT_i;
  logic [W-1:0] ACC_o;
  logic         Z_o;
  logic         C_o;
  logic         busy_o;
  logic         done_o;

  modport master (
    output start_i, op_i, ACT_i,
    input  ACC_o, Z_o, C_o, busy_o, done_o
  );

  modport slave (
    input  start_i, op_i, ACT_i,
    output ACC_o, Z_o, C_o, busy_o, done_o
  );

endinterface

// File: rtl/acc_alu_mul.sv
// Shift-add multiplier sequencer: W steps after a load, strobing o_step_done
// during the last step; o_product already includes that last partial add.
module acc_alu_mul
  import acc_alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  output logic             o_step_done,
  output logic [2*W-1:0]   o_product
);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   r_mcand;
  logic [W-1:0]     r_mplier;
  logic [2*W-1:0]   r_pp;
  logic [2*W-1:0]   w_pp_next;

  assign w_pp_next   = r_pp + (r_mplier[0] ? r_mcand : '0);
  assign o_step_done = r_busy && (r_cnt == CNT_W'(W - 1));
  assign o_product   = w_pp_next;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_pp     <= '0;
    end else if (i_load) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= {{W{1'b0}}, i_a};
      r_mplier <= i_b;
      r_pp     <= '0;
    end else if (r_busy) begin
      r_pp     <= w_pp_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (o_step_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/acc_alu.sv
// Accumulator/ALU stage: single-cycle ops commit on the accepting edge.
// ACC_ALU_MUL_EN selects a W-cycle MUL for opcode 111 instead of SHR.
module acc_alu
  import acc_alu_pkg::*;
(
  input  logic      C_i,
  input  logic      rst_ni,
  acc_alu_if.slave  bus
);

  state_t       r_state, w_state_next;
  logic [W-1:0] r_acc, w_acc_next;
  logic         r_c, w_c_next;
  op_t          w_op;
  logic [W-1:0] w_alu_res;
  logic         w_alu_c;
  logic [W:0]   w_sum;

  assign w_op = op_t'(bus.op_i);

`ifdef ACC_ALU_MUL_EN
  logic           w_mul_load;
  logic           w_step_done;
  logic [2*W-1:0] w_product;

  acc_alu_mul u_mul (
    .clk         (C_i),
    .rst_n       (rst_ni),
    .i_load      (w_mul_load),
    .i_a         (r_acc),
    .i_b         (bus.ACT_i),
    .o_step_done (w_step_done),
    .o_product   (w_product)
  );
`endif

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_sum     = {1'b0, r_acc} + {1'b0, bus.ACT_i};
    case (w_op)
      OP_LDA: w_alu_res = bus.ACT_i;
      OP_ADD: begin
        w_alu_res = w_sum[W-1:0];
        w_alu_c   = w_sum[W];
      end
      OP_SUB: begin
        w_alu_res = r_acc - bus.ACT_i;
        w_alu_c   = (r_acc < bus.ACT_i);
      end
      OP_AND: w_alu_res = r_acc & bus.ACT_i;
      OP_OR:  w_alu_res = r_acc | bus.ACT_i;
      OP_XOR: w_alu_res = r_acc ^ bus.ACT_i;
      OP_SHL: begin
        w_alu_res = {r_acc[W-2:0], 1'b0};
        w_alu_c   = r_acc[W-1];
      end
`ifndef ACC_ALU_MUL_EN
      OP_SHR: begin
        w_alu_res = {1'b0, r_acc[W-1:1]};
        w_alu_c   = r_acc[0];
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_c_next     = r_c;
`ifdef ACC_ALU_MUL_EN
    w_mul_load   = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start_i) begin
`ifdef ACC_ALU_MUL_EN
          if (w_op == OP_MUL) begin
            w_mul_load   = 1'b1;
            w_state_next = S_MUL;
          end else begin
`else
          begin
`endif
            w_acc_next   = w_alu_res;
            w_c_next     = w_alu_c;
            w_state_next = S_DONE;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_MUL: begin
`ifdef ACC_ALU_MUL_EN
        if (w_step_done) begin
          w_acc_next   = w_product[W-1:0];
          w_c_next     = |w_product[2*W-1:W];
          w_state_next = S_DONE;
        end
`else
        w_state_next = S_IDLE;
`endif
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge C_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_acc   <= RST_ACC;
      r_c     <= RST_C;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_c     <= w_c_next;
    end
  end

  assign bus.ACC_o  = r_acc;
  assign bus.Z_o    = (r_acc == '0);
  assign bus.C_o    = r_c;
  assign bus.done_o = (r_state == S_DONE);
`ifdef ACC_ALU_MUL_EN
  assign bus.busy_o = (r_state == S_MUL);
`else
  assign bus.busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_acc_alu.sv
// Directed self-checking bench for acc_alu; the MUL or SHR scenarios are
// selected by ACC_ALU_MUL_EN, matching the RTL build.
module tb_acc_alu;
  import acc_alu_pkg::*;

  localparam int OW = W + 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  acc_alu_if bus ();

  acc_alu dut (
    .C_i    (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Observed snapshot: {ACC, Z, C, busy, done}
  logic [OW-1:0] obs;
  assign obs = {bus.ACC_o, bus.Z_o, bus.C_o, bus.busy_o, bus.done_o};

  function automatic logic [OW-1:0] exp_v(input logic [W-1:0] acc, input logic c,
                                          input logic busy, input logic done);
    return {acc, (acc == '0), c, busy, done};
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] b);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.ACT_i   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [OW-1:0] e;
    #1;
    e = exp_v(4'b0000, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_initial: got %b expected %b", obs, e); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_LDA, 4'b1010);
    e = exp_v(4'b1010, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_preload: got %b expected %b", obs, e); end
    #1;
    rst_n = 1'b0;
    #1;
    e = exp_v(4'b0000, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_async: got %b expected %b", obs, e); end
    @(negedge clk);
    bus.start_i = 1'b0;
    rst_n       = 1'b1;
  endtask

  // Runs a table of back-to-back ops, checks each commit, then one idle cycle.
  task automatic run_table(input string name, input int n,
                           input logic [2:0] ops [8], input logic [W-1:0] bs [8],
                           input logic [W-1:0] accs [8], input logic cs [8]);
    logic [OW-1:0] e;
    for (int i = 0; i < n; i++) begin
      issue(ops[i], bs[i]);
      e = exp_v(accs[i], cs[i], 1'b0, 1'b1);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL %s[%0d]: got %b expected %b", name, i, obs, e); end
    end
    idle_cycle();
    e = exp_v(accs[n-1], cs[n-1], 1'b0, 1'b0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL %s_idle: got %b expected %b", name, obs, e); end
  endtask

  task automatic test_add();
    run_table("add", 2,
              '{OP_LDA, OP_ADD, 0, 0, 0, 0, 0, 0},
              '{4'b0101, 4'b1100, 0, 0, 0, 0, 0, 0},
              '{4'b0101, 4'b0001, 0, 0, 0, 0, 0, 0},
              '{1'b0, 1'b1, 0, 0, 0, 0, 0, 0});
  endtask

  task automatic test_sub_xor();
    run_table("sub_xor", 3,
              '{OP_LDA, OP_SUB, OP_XOR, 0, 0, 0, 0, 0},
              '{4'b0011, 4'b0101, 4'b1110, 0, 0, 0, 0, 0},
              '{4'b0011, 4'b1110, 4'b0000, 0, 0, 0, 0, 0},
              '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0});
  endtask

  task automatic test_logic();
    run_table("logic", 6,
              '{OP_LDA, OP_AND, OP_OR, OP_SHL, OP_ADD, OP_SUB, 0, 0},
              '{4'b1100, 4'b1010, 4'b0011, 4'b0000, 4'b1010, 4'b0001, 0, 0},
              '{4'b1100, 4'b1000, 4'b1011, 4'b0110, 4'b0000, 4'b1111, 0, 0},
              '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0});
  endtask

`ifdef ACC_ALU_MUL_EN
  task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] prod, input logic c);
    logic [OW-1:0] e;
    issue(OP_LDA, a);
    issue(OP_MUL, b);
    e = exp_v(a, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL %s_accept: got %b expected %b", name, obs, e); end
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i    = OP_LDA;
      bus.ACT_i   = ~b;
      @(posedge clk);
      #1;
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL %s_busy[%0d]: got %b expected %b", name, i, obs, e); end
    end
    idle_cycle();
    e = exp_v(prod, c, 1'b0, 1'b1);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL %s_commit: got %b expected %b", name, obs, e); end
    idle_cycle();
    e = exp_v(prod, c, 1'b0, 1'b0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL %s_idle: got %b expected %b", name, obs, e); end
  endtask

  task automatic test_op7();
    run_mul("mul_3x5", 4'b0011, 4'b0101, 4'b1111, 1'b0);
    run_mul("mul_6x6", 4'b0110, 4'b0110, 4'b0100, 1'b1);
  endtask

  task automatic test_reset_mid_op();
    logic [OW-1:0] e;
    issue(OP_LDA, 4'b0101);
    issue(OP_MUL, 4'b0011);
    idle_cycle();
    @(posedge clk);
    #1;
    e = exp_v(4'b0101, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL midmul_busy: got %b expected %b", obs, e); end
    #2;
    rst_n = 1'b0;
    #1;
    e = exp_v(4'b0000, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL midmul_reset: got %b expected %b", obs, e); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_LDA, 4'b1001);
    e = exp_v(4'b1001, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL midmul_lda: got %b expected %b", obs, e); end
    idle_cycle();
    run_mul("mul_after_reset", 4'b0010, 4'b0011, 4'b0110, 1'b0);
  endtask
`else
  task automatic test_op7();
    run_table("shr", 4,
              '{OP_LDA, OP_SHR, OP_SHR, OP_SHR, 0, 0, 0, 0},
              '{4'b1001, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0, 0},
              '{4'b1001, 4'b0100, 4'b0010, 4'b0001, 0, 0, 0, 0},
              '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0});
  endtask

  task automatic test_reset_mid_op();
    logic [OW-1:0] e;
    issue(OP_LDA, 4'b0101);
    issue(OP_SHL, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    e = exp_v(4'b0000, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL midop_reset: got %b expected %b", obs, e); end
    @(negedge clk);
    bus.start_i = 1'b0;
    rst_n       = 1'b1;
    issue(OP_LDA, 4'b1001);
    e = exp_v(4'b1001, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL midop_lda: got %b expected %b", obs, e); end
    idle_cycle();
  endtask
`endif

  initial begin
    bus.start_i = 1'b0;
    bus.op_i    = 3'b000;
    bus.ACT_i   = '0;
    test_reset();
    test_add();
    test_sub_xor();
    test_logic();
    test_op7();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
